axi_lite_sr_regfile: RTL and testbench
======================================

// Module: axi_lite_sr_regfile
// PURPOSE
// - Parametrised AXI4-Lite slave: NUM_REGS data registers that also form a shift chain, plus a STATUS/counter register.
// - Successor of the fixed 8-register block: adds generic width/depth, WSTRB byte lanes, SLVERR decode,
//   a streaming shift port and defined write/shift collision rules. Sits behind the BD master VIP / interconnect.
// PARAMETERS
// - DATA_WIDTH  32  AXI data and register width; 32 or 64.
// - NUM_REGS    8   shift-chain depth, 2..64.
// - ADDR_WIDTH  $clog2(NUM_REGS+1)+$clog2(DATA_WIDTH/8)  byte-address width.
// PORTS
// - ACLK            in   1            clock
// - ARESET          in   1            async reset, active-high
// - S_AXI_AWADDR    in   ADDR_WIDTH   write address
// - S_AXI_AWPROT    in   3            ignored
// - S_AXI_AWVALID / S_AXI_AWREADY   in/out  1   AW handshake
// - S_AXI_WDATA     in   DATA_WIDTH   write data
// - S_AXI_WSTRB     in   DATA_WIDTH/8 byte enables
// - S_AXI_WVALID / S_AXI_WREADY     in/out  1   W handshake
// - S_AXI_BRESP     out  2            00 OKAY, 10 SLVERR
// - S_AXI_BVALID / S_AXI_BREADY     out/in  1   B handshake
// - S_AXI_ARADDR    in   ADDR_WIDTH   read address
// - S_AXI_ARPROT    in   3            ignored
// - S_AXI_ARVALID / S_AXI_ARREADY   in/out  1   AR handshake
// - S_AXI_RDATA     out  DATA_WIDTH   read data
// - S_AXI_RRESP     out  2            00 OKAY, 10 SLVERR
// - S_AXI_RVALID / S_AXI_RREADY     out/in  1   R handshake
// - shift_in_valid  in   1            push request
// - shift_in_data   in   DATA_WIDTH   word entering reg[0]
// - shift_in_ready  out  1            constant 1 when out of reset
// - shift_out_valid out  1            one-cycle strobe, evicted word valid
// - shift_out_data  out  DATA_WIDTH   word evicted from reg[NUM_REGS-1]
// BEHAVIOUR
// - Reset: all regs, STATUS, BVALID, RVALID, shift_out_valid, shift_out_data, RDATA, responses = 0;
//   AWREADY/WREADY/ARREADY = 0 during reset, 1 in the first cycle after release. Reset mid-transaction discards it; no B/R issued.
// - Map: index = addr >> log2(DATA_WIDTH/8); 0..NUM_REGS-1 = reg[i]; NUM_REGS = STATUS (shift count, wraps at 2^DATA_WIDTH);
//   index > NUM_REGS -> SLVERR, write ignored, RDATA = 0. Low address bits ignored.
// - Write FSM W_IDLE -> W_RESP: AW and W captured independently (either order or same cycle); each READY drops after its
//   own handshake. Commit on the edge after both are held; BVALID rises that edge, held until BREADY; then READYs reassert.
//   One write outstanding.
// - STATUS write (any strobe) clears it to 0, BRESP OKAY.
// - WSTRB: only enabled byte lanes update; WSTRB = 0 commits nothing but returns OKAY.
// - Read FSM R_IDLE -> R_DATA: ARREADY high in R_IDLE; RDATA/RRESP registered the edge after handshake, sampling pre-edge
//   register state; RVALID held until RREADY. One read outstanding; independent of write path.
// - Shift: shift_in_valid & shift_in_ready -> at edge: reg[i+1] <= reg[i], reg[0] <= shift_in_data,
//   shift_out_data <= old reg[NUM_REGS-1], shift_out_valid = 1 for one cycle, STATUS += 1.
// - Collision, same edge: shift applied first, then AXI write bytes override the post-shift target register
//   (write wins on its index). STATUS clear beats increment.
// STRUCTURE
// - Package axi_lite_sr_pkg: resp_t (OKAY, SLVERR), wr_state_t, rd_state_t, STATUS index helper function.
// - One sub-module sr_regfile_core: register array, shift chain, STATUS counter, byte-masked write port and read mux.
//   AXI FSMs live in the top level.
// TESTING
// - Seq write/read: write 1,2,3,4 to 0x0,0x4,0x8,0xC, read back -> 1..4, RRESP/BRESP = 00.
// - Order and strobes: W before AW by 3 cycles, WSTRB = 0011, data 0xAABBCCDD onto reg[1] = 0x11223344
//   -> read 0x1122CCDD; single B.
// - Shift: preload reg[i] = i+1, push 0xA0,0xA1 -> shift_out 8 then 7; reg[0] = 0xA1, reg[1] = 0xA0; STATUS = 2.
// - Collision: shift and AXI write 0x55 to reg[0] on the same edge -> reg[0] = 0x55, reg[1] = old reg[0]; STATUS write
//   plus shift on the same edge -> STATUS = 0.
// - Decode: write/read index NUM_REGS+1 -> SLVERR, RDATA = 0, no register changes.
// - Reset: assert ARESET while BVALID is pending and BREADY = 0 -> BVALID = 0, regs = 0, next write completes normally.

Source files
------------

// File: rtl/axi_lite_sr_pkg.sv
// Shared types and helpers for the AXI4-Lite shift-register file.
package axi_lite_sr_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } resp_t;

  typedef enum logic {
    W_IDLE,
    W_RESP
  } wr_state_t;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rd_state_t;

  // STATUS sits directly after the last data register in the word map.
  function automatic int unsigned status_index(input int unsigned num_regs);
    return num_regs;
  endfunction

endpackage

// File: rtl/sr_regfile_core.sv
// Register array with shift chain, STATUS shift counter, byte-masked write port and read mux.
module sr_regfile_core
  import axi_lite_sr_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REGS   = 8,
  parameter int unsigned IDX_W      = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    shift_en,
  input  logic [DATA_WIDTH-1:0]   shift_data,
  input  logic                    wr_en,
  input  logic [IDX_W-1:0]        wr_idx,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_strb,
  input  logic [IDX_W-1:0]        rd_idx,
  output logic [DATA_WIDTH-1:0]   rd_data_c,
  output logic                    shift_out_valid,
  output logic [DATA_WIDTH-1:0]   shift_out_data
);

  localparam int unsigned BYTES = DATA_WIDTH / 8;
  localparam logic [IDX_W-1:0] STATUS_IDX = IDX_W'(status_index(NUM_REGS));

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
  logic [DATA_WIDTH-1:0] status_q;
  logic [DATA_WIDTH-1:0] status_d;

  // Next register state: shift first, then the AXI write overrides its target bytes.
  always_comb begin
    regs_d   = regs_q;
    status_d = status_q;
    if (shift_en) begin
      regs_d[0] = shift_data;
      for (int i = 1; i < NUM_REGS; i++) begin
        regs_d[i] = regs_q[i-1];
      end
      status_d = status_q + DATA_WIDTH'(1);
    end
    if (wr_en) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_idx == IDX_W'(i)) begin
          for (int b = 0; b < BYTES; b++) begin
            if (wr_strb[b]) begin
              regs_d[i][8*b +: 8] = wr_data[8*b +: 8];
            end
          end
        end
      end
      if (wr_idx == STATUS_IDX) begin
        status_d = '0;
      end
    end
  end

  // Read mux; indices past STATUS return zero.
  always_comb begin
    rd_data_c = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_idx == IDX_W'(i)) begin
        rd_data_c = regs_q[i];
      end
    end
    if (rd_idx == STATUS_IDX) begin
      rd_data_c = status_q;
    end
  end

  // State registers and the one-cycle eviction strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_q          <= '{default: '0};
      status_q        <= '0;
      shift_out_valid <= 1'b0;
      shift_out_data  <= '0;
    end else begin
      regs_q          <= regs_d;
      status_q        <= status_d;
      shift_out_valid <= shift_en;
      if (shift_en) begin
        shift_out_data <= regs_q[NUM_REGS-1];
      end
    end
  end

endmodule

// File: rtl/axi_lite_sr_regfile.sv
// AXI4-Lite slave front end for the shift-register file: write and read channel FSMs.
module axi_lite_sr_regfile
  import axi_lite_sr_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REGS   = 8,
  parameter int unsigned ADDR_WIDTH = $clog2(NUM_REGS+1) + $clog2(DATA_WIDTH/8)
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]              S_AXI_AWPROT,
  input  logic                    S_AXI_AWVALID,
  output logic                    S_AXI_AWREADY,
  input  logic [DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                    S_AXI_WVALID,
  output logic                    S_AXI_WREADY,
  output logic [1:0]              S_AXI_BRESP,
  output logic                    S_AXI_BVALID,
  input  logic                    S_AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]              S_AXI_ARPROT,
  input  logic                    S_AXI_ARVALID,
  output logic                    S_AXI_ARREADY,
  output logic [DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]              S_AXI_RRESP,
  output logic                    S_AXI_RVALID,
  input  logic                    S_AXI_RREADY,
  input  logic                    shift_in_valid,
  input  logic [DATA_WIDTH-1:0]   shift_in_data,
  output logic                    shift_in_ready,
  output logic                    shift_out_valid,
  output logic [DATA_WIDTH-1:0]   shift_out_data
);

  localparam int unsigned BYTES = DATA_WIDTH / 8;
  localparam int unsigned LSB   = $clog2(BYTES);
  localparam int unsigned IDX_W = ADDR_WIDTH - LSB;
  localparam logic [IDX_W-1:0] STATUS_IDX = IDX_W'(status_index(NUM_REGS));

  // Write channel state
  wr_state_t             wr_state, wr_state_d;
  logic                  aw_held, aw_held_d, w_held, w_held_d;
  logic                  awready_q, awready_d, wready_q, wready_d;
  logic                  bvalid_q, bvalid_d;
  resp_t                 bresp_q, bresp_d;
  logic [IDX_W-1:0]      aw_idx_q, aw_idx_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [BYTES-1:0]      wstrb_q, wstrb_d;
  logic                  wr_commit_c;

  // Read channel state
  rd_state_t             rd_state, rd_state_d;
  logic                  arready_q, arready_d, rvalid_q, rvalid_d;
  resp_t                 rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [IDX_W-1:0]      ar_idx_c;
  logic [DATA_WIDTH-1:0] core_rd_data_c;
  logic                  shift_en_c;

  logic unused_bits;
  assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[LSB-1:0], S_AXI_ARADDR[LSB-1:0]};

  assign wr_commit_c = (wr_state == W_IDLE) && aw_held && w_held;
  assign ar_idx_c    = S_AXI_ARADDR[ADDR_WIDTH-1:LSB];
  assign shift_en_c  = shift_in_valid && shift_in_ready;

  // Ready flops reset high but are masked while reset is asserted.
  assign S_AXI_AWREADY  = awready_q && !ARESET;
  assign S_AXI_WREADY   = wready_q  && !ARESET;
  assign S_AXI_ARREADY  = arready_q && !ARESET;
  assign shift_in_ready = !ARESET;
  assign S_AXI_BVALID   = bvalid_q;
  assign S_AXI_BRESP    = bresp_q;
  assign S_AXI_RVALID   = rvalid_q;
  assign S_AXI_RRESP    = rresp_q;
  assign S_AXI_RDATA    = rdata_q;

  // Write FSM next state: independent AW/W capture, commit once both are held.
  always_comb begin
    wr_state_d = wr_state;
    aw_held_d  = aw_held;
    w_held_d   = w_held;
    awready_d  = awready_q;
    wready_d   = wready_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    aw_idx_d   = aw_idx_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    case (wr_state)
      W_IDLE: begin
        if (S_AXI_AWVALID && awready_q) begin
          aw_held_d = 1'b1;
          awready_d = 1'b0;
          aw_idx_d  = S_AXI_AWADDR[ADDR_WIDTH-1:LSB];
        end
        if (S_AXI_WVALID && wready_q) begin
          w_held_d = 1'b1;
          wready_d = 1'b0;
          wdata_d  = S_AXI_WDATA;
          wstrb_d  = S_AXI_WSTRB;
        end
        if (wr_commit_c) begin
          bvalid_d   = 1'b1;
          bresp_d    = (aw_idx_q > STATUS_IDX) ? RESP_SLVERR : RESP_OKAY;
          wr_state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (S_AXI_BREADY) begin
          bvalid_d   = 1'b0;
          bresp_d    = RESP_OKAY;
          aw_held_d  = 1'b0;
          w_held_d   = 1'b0;
          awready_d  = 1'b1;
          wready_d   = 1'b1;
          wr_state_d = W_IDLE;
        end
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  // Write FSM registers.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wr_state  <= W_IDLE;
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      awready_q <= 1'b1;
      wready_q  <= 1'b1;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      aw_idx_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      wr_state  <= wr_state_d;
      aw_held   <= aw_held_d;
      w_held    <= w_held_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      aw_idx_q  <= aw_idx_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
    end
  end

  // Read FSM next state: sample the register file on the AR handshake edge.
  always_comb begin
    rd_state_d = rd_state;
    arready_d  = arready_q;
    rvalid_d   = rvalid_q;
    rresp_d    = rresp_q;
    rdata_d    = rdata_q;
    case (rd_state)
      R_IDLE: begin
        if (S_AXI_ARVALID && arready_q) begin
          rdata_d    = core_rd_data_c;
          rresp_d    = (ar_idx_c > STATUS_IDX) ? RESP_SLVERR : RESP_OKAY;
          rvalid_d   = 1'b1;
          arready_d  = 1'b0;
          rd_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (S_AXI_RREADY) begin
          rvalid_d   = 1'b0;
          arready_d  = 1'b1;
          rd_state_d = R_IDLE;
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  // Read FSM registers.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      rd_state  <= R_IDLE;
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
    end else begin
      rd_state  <= rd_state_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
    end
  end

  sr_regfile_core #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .IDX_W      (IDX_W)
  ) u_core (
    .clk             (ACLK),
    .rst             (ARESET),
    .shift_en        (shift_en_c),
    .shift_data      (shift_in_data),
    .wr_en           (wr_commit_c),
    .wr_idx          (aw_idx_q),
    .wr_data         (wdata_q),
    .wr_strb         (wstrb_q),
    .rd_idx          (ar_idx_c),
    .rd_data_c       (core_rd_data_c),
    .shift_out_valid (shift_out_valid),
    .shift_out_data  (shift_out_data)
  );

endmodule

// File: tb/tb_axi_lite_sr_regfile.sv
// Directed self-checking bench for axi_lite_sr_regfile (32-bit data, 8 registers).
module tb_axi_lite_sr_regfile;

  localparam int unsigned DW = 32;
  localparam int unsigned NR = 8;
  localparam int unsigned AW = 6;

  logic          ACLK = 1'b0;
  logic          ARESET;
  logic [AW-1:0] S_AXI_AWADDR;
  logic [2:0]    S_AXI_AWPROT;
  logic          S_AXI_AWVALID;
  logic          S_AXI_AWREADY;
  logic [DW-1:0] S_AXI_WDATA;
  logic [3:0]    S_AXI_WSTRB;
  logic          S_AXI_WVALID;
  logic          S_AXI_WREADY;
  logic [1:0]    S_AXI_BRESP;
  logic          S_AXI_BVALID;
  logic          S_AXI_BREADY;
  logic [AW-1:0] S_AXI_ARADDR;
  logic [2:0]    S_AXI_ARPROT;
  logic          S_AXI_ARVALID;
  logic          S_AXI_ARREADY;
  logic [DW-1:0] S_AXI_RDATA;
  logic [1:0]    S_AXI_RRESP;
  logic          S_AXI_RVALID;
  logic          S_AXI_RREADY;
  logic          shift_in_valid;
  logic [DW-1:0] shift_in_data;
  logic          shift_in_ready;
  logic          shift_out_valid;
  logic [DW-1:0] shift_out_data;

  int total = 0;
  int bad   = 0;

  always #5 ACLK = ~ACLK;

  axi_lite_sr_regfile #(.DATA_WIDTH(DW), .NUM_REGS(NR)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .shift_in_valid(shift_in_valid), .shift_in_data(shift_in_data),
    .shift_in_ready(shift_in_ready),
    .shift_out_valid(shift_out_valid), .shift_out_data(shift_out_data)
  );

  // Bus driver: full write transaction, returns BRESP.
  task automatic axi_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
    bit aw_done, w_done, aw_hs, w_hs, got;
    aw_done = 0; w_done = 0; got = 0; resp = 2'b11;
    @(negedge ACLK);
    S_AXI_AWADDR = addr; S_AXI_WDATA = data; S_AXI_WSTRB = strb;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    for (int c = 0; c < 20 && !(aw_done && w_done); c++) begin
      aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
      w_hs  = S_AXI_WVALID && S_AXI_WREADY;
      @(posedge ACLK); @(negedge ACLK);
      if (aw_hs) begin aw_done = 1; S_AXI_AWVALID = 1'b0; end
      if (w_hs)  begin w_done = 1;  S_AXI_WVALID  = 1'b0; end
    end
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    if (!(aw_done && w_done)) begin
      total++; bad++; $display("FAIL wr_handshake_timeout addr=%h", addr);
    end
    S_AXI_BREADY = 1'b1;
    for (int c = 0; c < 20 && !got; c++) begin
      if (S_AXI_BVALID) begin got = 1; resp = S_AXI_BRESP; end
      @(posedge ACLK); @(negedge ACLK);
    end
    S_AXI_BREADY = 1'b0;
    if (!got) begin
      total++; bad++; $display("FAIL wr_bvalid_timeout addr=%h", addr);
    end
  endtask

  // Bus driver: full read transaction, returns RDATA and RRESP.
  task automatic axi_read(input logic [AW-1:0] addr, output logic [DW-1:0] data,
                          output logic [1:0] resp);
    bit ar_done, ar_hs, got;
    ar_done = 0; got = 0; data = 'x; resp = 2'b11;
    @(negedge ACLK);
    S_AXI_ARADDR = addr; S_AXI_ARVALID = 1'b1;
    for (int c = 0; c < 20 && !ar_done; c++) begin
      ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;
      @(posedge ACLK); @(negedge ACLK);
      if (ar_hs) begin ar_done = 1; S_AXI_ARVALID = 1'b0; end
    end
    S_AXI_ARVALID = 1'b0;
    if (!ar_done) begin
      total++; bad++; $display("FAIL rd_handshake_timeout addr=%h", addr);
    end
    S_AXI_RREADY = 1'b1;
    for (int c = 0; c < 20 && !got; c++) begin
      if (S_AXI_RVALID) begin got = 1; data = S_AXI_RDATA; resp = S_AXI_RRESP; end
      @(posedge ACLK); @(negedge ACLK);
    end
    S_AXI_RREADY = 1'b0;
    if (!got) begin
      total++; bad++; $display("FAIL rd_rvalid_timeout addr=%h", addr);
    end
  endtask

  task automatic test_reset();
    logic [DW-1:0] d; logic [1:0] r;
    ARESET = 1'b1;
    S_AXI_AWADDR = '0; S_AXI_AWPROT = '0; S_AXI_AWVALID = 0; S_AXI_WDATA = '0;
    S_AXI_WSTRB = '0; S_AXI_WVALID = 0; S_AXI_BREADY = 0; S_AXI_ARADDR = '0;
    S_AXI_ARPROT = '0; S_AXI_ARVALID = 0; S_AXI_RREADY = 0;
    shift_in_valid = 0; shift_in_data = '0;
    repeat (3) @(negedge ACLK);
    total++;
    if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, shift_in_ready} !== 4'b0000) begin
      bad++; $display("FAIL reset_readys got=%b exp=0000",
        {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, shift_in_ready});
    end
    total++;
    if ({S_AXI_BVALID, S_AXI_RVALID, shift_out_valid, S_AXI_BRESP, S_AXI_RRESP} !== 7'b0) begin
      bad++; $display("FAIL reset_valids got=%b exp=0",
        {S_AXI_BVALID, S_AXI_RVALID, shift_out_valid, S_AXI_BRESP, S_AXI_RRESP});
    end
    total++;
    if ({S_AXI_RDATA, shift_out_data} !== 64'b0) begin
      bad++; $display("FAIL reset_data got=%h_%h exp=0", S_AXI_RDATA, shift_out_data);
    end
    ARESET = 1'b0;
    #1;
    total++;
    if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, shift_in_ready} !== 4'b1111) begin
      bad++; $display("FAIL release_readys got=%b exp=1111",
        {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, shift_in_ready});
    end
    axi_read(6'h00, d, r);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL reset_reg0 got=%h exp=0", d); end
    axi_read(6'h20, d, r);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL reset_status got=%h exp=0", d); end
  endtask

  task automatic test_seq_write_read();
    logic [DW-1:0] d; logic [1:0] r;
    for (int i = 0; i < 4; i++) begin
      axi_write(AW'(i * 4), DW'(i + 1), 4'hF, r);
      total++;
      if (r !== 2'b00) begin bad++; $display("FAIL seq_bresp[%0d] got=%b exp=00", i, r); end
    end
    for (int i = 0; i < 4; i++) begin
      axi_read(AW'(i * 4), d, r);
      total++;
      if (d !== DW'(i + 1) || r !== 2'b00) begin
        bad++; $display("FAIL seq_read[%0d] got=%h/%b exp=%h/00", i, d, r, i + 1);
      end
    end
  endtask

  task automatic test_order_strobe();
    logic [DW-1:0] d; logic [1:0] r; int bcount; bit got;
    axi_write(6'h04, 32'h11223344, 4'hF, r);
    @(negedge ACLK);
    S_AXI_WDATA = 32'hAABBCCDD; S_AXI_WSTRB = 4'b0011; S_AXI_WVALID = 1'b1;
    @(posedge ACLK); @(negedge ACLK);
    S_AXI_WVALID = 1'b0;
    total++;
    if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID} !== 3'b100) begin
      bad++; $display("FAIL w_first_readys got=%b exp=100",
        {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID});
    end
    repeat (2) @(negedge ACLK);
    S_AXI_AWADDR = 6'h04; S_AXI_AWVALID = 1'b1;
    @(posedge ACLK); @(negedge ACLK);
    S_AXI_AWVALID = 1'b0;
    got = 0;
    for (int c = 0; c < 10 && !got; c++) begin
      if (S_AXI_BVALID) got = 1;
      else @(negedge ACLK);
    end
    total++;
    if (!got || S_AXI_BRESP !== 2'b00) begin
      bad++; $display("FAIL w_first_bresp got=%b/%b exp=1/00", got, S_AXI_BRESP);
    end
    S_AXI_BREADY = 1'b1;
    @(posedge ACLK); @(negedge ACLK);
    S_AXI_BREADY = 1'b0;
    bcount = 0;
    for (int c = 0; c < 4; c++) begin
      if (S_AXI_BVALID) bcount++;
      @(negedge ACLK);
    end
    total++;
    if (bcount !== 0) begin bad++; $display("FAIL single_b got=%0d extra exp=0", bcount); end
    axi_read(6'h04, d, r);
    total++;
    if (d !== 32'h1122CCDD) begin bad++; $display("FAIL strobe_read got=%h exp=1122ccdd", d); end
    axi_write(6'h04, 32'hFFFFFFFF, 4'b0000, r);
    total++;
    if (r !== 2'b00) begin bad++; $display("FAIL zero_strb_bresp got=%b exp=00", r); end
    axi_read(6'h04, d, r);
    total++;
    if (d !== 32'h1122CCDD) begin bad++; $display("FAIL zero_strb_read got=%h exp=1122ccdd", d); end
  endtask

  task automatic test_shift();
    logic [DW-1:0] d; logic [1:0] r;
    for (int i = 0; i < 8; i++) axi_write(AW'(i * 4), DW'(i + 1), 4'hF, r);
    axi_write(6'h20, 32'h0, 4'hF, r);
    @(negedge ACLK);
    shift_in_valid = 1'b1; shift_in_data = 32'hA0;
    @(posedge ACLK); @(negedge ACLK);
    total++;
    if (shift_out_valid !== 1'b1 || shift_out_data !== 32'h8) begin
      bad++; $display("FAIL shift_out_0 got=%b/%h exp=1/8", shift_out_valid, shift_out_data);
    end
    shift_in_data = 32'hA1;
    @(posedge ACLK); @(negedge ACLK);
    shift_in_valid = 1'b0;
    total++;
    if (shift_out_valid !== 1'b1 || shift_out_data !== 32'h7) begin
      bad++; $display("FAIL shift_out_1 got=%b/%h exp=1/7", shift_out_valid, shift_out_data);
    end
    @(posedge ACLK); @(negedge ACLK);
    total++;
    if (shift_out_valid !== 1'b0) begin bad++; $display("FAIL shift_strobe_len got=%b exp=0", shift_out_valid); end
    axi_read(6'h00, d, r);
    total++;
    if (d !== 32'hA1) begin bad++; $display("FAIL shift_reg0 got=%h exp=a1", d); end
    axi_read(6'h04, d, r);
    total++;
    if (d !== 32'hA0) begin bad++; $display("FAIL shift_reg1 got=%h exp=a0", d); end
    axi_read(6'h08, d, r);
    total++;
    if (d !== 32'h1) begin bad++; $display("FAIL shift_reg2 got=%h exp=1", d); end
    axi_read(6'h20, d, r);
    total++;
    if (d !== 32'h2) begin bad++; $display("FAIL shift_status got=%h exp=2", d); end
  endtask

  task automatic test_collision();
    logic [DW-1:0] d; logic [1:0] r;
    // regs = A1,A0,1..6 ; STATUS = 2
    @(negedge ACLK);
    S_AXI_AWADDR = 6'h00; S_AXI_WDATA = 32'h55; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    @(posedge ACLK); @(negedge ACLK);
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    shift_in_valid = 1'b1; shift_in_data = 32'h77;
    @(posedge ACLK); @(negedge ACLK);
    shift_in_valid = 1'b0;
    total++;
    if ({S_AXI_BVALID, S_AXI_BRESP, shift_out_valid} !== 4'b1001 || shift_out_data !== 32'h6) begin
      bad++; $display("FAIL coll_edge got=%b/%h exp=1001/6",
        {S_AXI_BVALID, S_AXI_BRESP, shift_out_valid}, shift_out_data);
    end
    S_AXI_BREADY = 1'b1;
    @(posedge ACLK); @(negedge ACLK);
    S_AXI_BREADY = 1'b0;
    axi_read(6'h00, d, r);
    total++;
    if (d !== 32'h55) begin bad++; $display("FAIL coll_reg0 got=%h exp=55", d); end
    axi_read(6'h04, d, r);
    total++;
    if (d !== 32'hA1) begin bad++; $display("FAIL coll_reg1 got=%h exp=a1", d); end
    axi_read(6'h20, d, r);
    total++;
    if (d !== 32'h3) begin bad++; $display("FAIL coll_status_inc got=%h exp=3", d); end
    // STATUS clear on the same edge as a shift
    @(negedge ACLK);
    S_AXI_AWADDR = 6'h20; S_AXI_WDATA = 32'hFFFFFFFF; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    @(posedge ACLK); @(negedge ACLK);
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    shift_in_valid = 1'b1; shift_in_data = 32'h99;
    @(posedge ACLK); @(negedge ACLK);
    shift_in_valid = 1'b0;
    total++;
    if (S_AXI_BVALID !== 1'b1 || shift_out_data !== 32'h5) begin
      bad++; $display("FAIL coll2_edge got=%b/%h exp=1/5", S_AXI_BVALID, shift_out_data);
    end
    S_AXI_BREADY = 1'b1;
    @(posedge ACLK); @(negedge ACLK);
    S_AXI_BREADY = 1'b0;
    axi_read(6'h20, d, r);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL coll_status_clear got=%h exp=0", d); end
    axi_read(6'h00, d, r);
    total++;
    if (d !== 32'h99) begin bad++; $display("FAIL coll2_reg0 got=%h exp=99", d); end
    axi_read(6'h04, d, r);
    total++;
    if (d !== 32'h55) begin bad++; $display("FAIL coll2_reg1 got=%h exp=55", d); end
  endtask

  task automatic test_decode();
    logic [DW-1:0] d; logic [1:0] r;
    axi_write(6'h24, 32'hFFFFFFFF, 4'hF, r);
    total++;
    if (r !== 2'b10) begin bad++; $display("FAIL dec_bresp got=%b exp=10", r); end
    axi_read(6'h24, d, r);
    total++;
    if (d !== 32'h0 || r !== 2'b10) begin bad++; $display("FAIL dec_read9 got=%h/%b exp=0/10", d, r); end
    axi_read(6'h3C, d, r);
    total++;
    if (d !== 32'h0 || r !== 2'b10) begin bad++; $display("FAIL dec_read15 got=%h/%b exp=0/10", d, r); end
    axi_read(6'h00, d, r);
    total++;
    if (d !== 32'h99 || r !== 2'b00) begin bad++; $display("FAIL dec_reg0 got=%h/%b exp=99/00", d, r); end
    axi_read(6'h1C, d, r);
    total++;
    if (d !== 32'h4) begin bad++; $display("FAIL dec_reg7 got=%h exp=4", d); end
    axi_read(6'h20, d, r);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL dec_status got=%h exp=0", d); end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] d; logic [1:0] r; bit got;
    @(negedge ACLK);
    S_AXI_AWADDR = 6'h00; S_AXI_WDATA = 32'hDEAD; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_BREADY = 1'b0;
    @(posedge ACLK); @(negedge ACLK);
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    got = 0;
    for (int c = 0; c < 10 && !got; c++) begin
      if (S_AXI_BVALID) got = 1;
      else @(negedge ACLK);
    end
    repeat (2) @(negedge ACLK);
    total++;
    if (S_AXI_BVALID !== 1'b1) begin bad++; $display("FAIL bvalid_pending got=%b exp=1", S_AXI_BVALID); end
    ARESET = 1'b1;
    #1;
    total++;
    if (S_AXI_BVALID !== 1'b0) begin bad++; $display("FAIL rst_bvalid got=%b exp=0", S_AXI_BVALID); end
    @(negedge ACLK);
    ARESET = 1'b0;
    axi_read(6'h00, d, r);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL rst_reg0 got=%h exp=0", d); end
    axi_read(6'h04, d, r);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL rst_reg1 got=%h exp=0", d); end
    axi_write(6'h08, 32'h1234, 4'hF, r);
    total++;
    if (r !== 2'b00) begin bad++; $display("FAIL post_rst_bresp got=%b exp=00", r); end
    axi_read(6'h08, d, r);
    total++;
    if (d !== 32'h1234) begin bad++; $display("FAIL post_rst_read got=%h exp=1234", d); end
  endtask

  initial begin
    test_reset();
    test_seq_write_read();
    test_order_strobe();
    test_shift();
    test_collision();
    test_decode();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
